serializer: RTL and testbench

Parallel-to-serial stream converter: accepts one DataWidth-bit word per valid/ready handshake and emits it as DataWidth/SerWidth consecutive SerWidth-bit beats, LSB slice first, on a valid/ready serial output. It is the transmit-side counterpart to our shift-in delay and capture logic. It sits between wide datapath producers and narrow links (debug/trace ports, narrow interconnect lanes). Full throughput is sustained: back-to-back words produce no bubble beats.

---
 rtl/serializer.sv | 81 ++++++++
 tb/tb_serializer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serializer.sv
// Parallel-to-serial stream converter: one wide word in, NumBeats
// narrow beats out, LSB slice first, valid/ready on both sides.
module serializer #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned SerWidth  = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clear_i,
  input  logic [DataWidth-1:0] data_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  output logic [SerWidth-1:0]  ser_o,
  output logic                 ser_valid_o,
  input  logic                 ser_ready_i,
  output logic                 ser_last_o,
  output logic                 busy_o
);

  localparam int unsigned NumBeats = DataWidth / SerWidth;
  localparam int unsigned CntW =
    (NumBeats > 1) ? $clog2(NumBeats) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(NumBeats - 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  if (DataWidth < SerWidth || (DataWidth % SerWidth) != 0) begin : g_bad_cfg
    $error("serializer: DataWidth must be a multiple of SerWidth");
  end

  logic [0:0]           state_q;
  logic [DataWidth-1:0] shreg_q;
  logic [CntW-1:0]      cnt_q;
  logic                 last;
  logic                 in_hs;
  logic                 ser_hs;

  assign busy_o      = (state_q == SHIFT);
  assign ser_valid_o = busy_o;
  assign last        = busy_o && (cnt_q == LastCnt);
  assign ser_last_o  = last;
  assign ser_o       = shreg_q[SerWidth-1:0];

  // Accept during the final beat so back-to-back words leave no bubble.
  assign ready_o = !clear_i && (!busy_o || (last && ser_ready_i));
  assign in_hs   = valid_i && ready_o;
  assign ser_hs  = busy_o && ser_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      priority case (1'b1)
        clear_i: begin
          state_q <= IDLE;
          shreg_q <= '0;
          cnt_q   <= '0;
        end
        in_hs: begin
          state_q <= SHIFT;
          shreg_q <= data_i;
          cnt_q   <= '0;
        end
        (ser_hs && last): begin
          state_q <= IDLE;
          shreg_q <= '0;
          cnt_q   <= '0;
        end
        ser_hs: begin
          shreg_q <= shreg_q >> SerWidth;
          cnt_q   <= cnt_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serializer.sv
// Bench for serializer: directed cases and random traffic on a 32/8
// instance, random traffic on a degenerate 8/8 instance.
module tb_serializer;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  // 32/8 instance
  logic        clear_a = 0, valid_a = 0, sready_a = 0;
  logic [31:0] data_a = 0;
  logic        ready_a, sval_a, last_a, busy_a;
  logic [7:0]  ser_a;

  // 8/8 instance
  logic        clear_b = 0, valid_b = 0, sready_b = 0;
  logic [7:0]  data_b = 0;
  logic        ready_b, sval_b, last_b, busy_b;
  logic [7:0]  ser_b;

  serializer #(.DataWidth(32), .SerWidth(8)) u_a (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear_a),
    .data_i(data_a), .valid_i(valid_a), .ready_o(ready_a),
    .ser_o(ser_a), .ser_valid_o(sval_a), .ser_ready_i(sready_a),
    .ser_last_o(last_a), .busy_o(busy_a)
  );

  serializer #(.DataWidth(8), .SerWidth(8)) u_b (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear_b),
    .data_i(data_b), .valid_i(valid_b), .ready_o(ready_b),
    .ser_o(ser_b), .ser_valid_o(sval_b), .ser_ready_i(sready_b),
    .ser_last_o(last_b), .busy_o(busy_b)
  );

  int nvec = 0;
  int nerr = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: queue of beats still owed for the word in flight.
  typedef struct {
    logic [7:0] d;
    logic       l;
  } beat_t;
  beat_t      qa[$];
  logic [7:0] qb[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qa.delete();
      qb.delete();
    end else begin
      bit    ra, rb;
      beat_t bt;
      ra = !clear_a && (qa.size() == 0 || (qa.size() == 1 && sready_a));
      rb = !clear_b && (qb.size() == 0 || sready_b);
      if (clear_a) qa.delete();
      else begin
        if (qa.size() > 0 && sready_a) void'(qa.pop_front());
        if (valid_a && ra)
          for (int i = 0; i < 4; i++) begin
            bt.d = data_a[8*i +: 8];
            bt.l = (i == 3);
            qa.push_back(bt);
          end
      end
      if (clear_b) qb.delete();
      else begin
        if (qb.size() > 0 && sready_b) void'(qb.pop_front());
        if (valid_b && rb) qb.push_back(data_b);
      end
    end
  end

  // Observed beat log and per-test counters for the directed cases
  logic [8:0] log_a[$];
  int vcyc = 0, lcnt = 0, rpulse = 0;

  always @(negedge clk) begin
    logic       ev;
    logic [7:0] eo;
    logic       el;
    ev = (qa.size() != 0);
    eo = ev ? qa[0].d : 8'h00;
    el = ev ? qa[0].l : 1'b0;
    chk("a_valid", {31'b0, sval_a}, {31'b0, ev});
    chk("a_busy", {31'b0, busy_a}, {31'b0, ev});
    chk("a_ser", {24'b0, ser_a}, {24'b0, eo});
    chk("a_last", {31'b0, last_a}, {31'b0, el});
    chk("a_ready", {31'b0, ready_a},
        {31'b0, !clear_a && (!ev || (qa.size() == 1 && sready_a))});
    if (sval_a) vcyc++;
    if (sval_a && last_a) lcnt++;
    if (sval_a && ready_a) rpulse++;
    if (sval_a && sready_a) log_a.push_back({last_a, ser_a});

    ev = (qb.size() != 0);
    eo = ev ? qb[0] : 8'h00;
    chk("b_valid", {31'b0, sval_b}, {31'b0, ev});
    chk("b_ser", {24'b0, ser_b}, {24'b0, eo});
    chk("b_last", {31'b0, last_b}, {31'b0, ev});
    chk("b_ready", {31'b0, ready_b},
        {31'b0, !clear_b && (!ev || sready_b)});
  end

  task automatic drv(logic v, logic [31:0] d, logic sr, logic cl);
    valid_a  = v;
    data_a   = d;
    sready_a = sr;
    clear_a  = cl;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) drv(0, 32'h0, 1, 0);
  endtask

  task automatic start_test();
    log_a.delete();
    vcyc = 0;
    lcnt = 0;
    rpulse = 0;
  endtask

  task automatic chk_log(string name, logic [8:0] e[$]);
    chk({name, "_len"}, log_a.size(), e.size());
    for (int i = 0; i < e.size(); i++)
      if (i < log_a.size()) chk(name, {23'b0, log_a[i]}, {23'b0, e[i]});
  endtask

  bit b_done = 0;

  initial begin
    #1 rst_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    chk("rst_ready", {31'b0, ready_a}, 1);
    chk("rst_valid", {31'b0, sval_a}, 0);
    chk("rst_ser", {24'b0, ser_a}, 0);
    chk("rst_last", {31'b0, last_a}, 0);
    chk("rst_busy", {31'b0, busy_a}, 0);

    // single word
    start_test();
    drv(1, 32'hDDCCBBAA, 1, 0);
    idle(6);
    chk_log("single", '{9'h0AA, 9'h0BB, 9'h0CC, 9'h1DD});
    chk("single_vcyc", vcyc, 4);
    chk("single_rpulse", rpulse, 1);

    // backpressure while 0xBB is presented
    start_test();
    drv(1, 32'hDDCCBBAA, 1, 0);
    drv(0, 32'h0, 1, 0);
    repeat (3) drv(0, 32'h0, 0, 0);
    idle(6);
    chk_log("bp", '{9'h0AA, 9'h0BB, 9'h0CC, 9'h1DD});
    chk("bp_vcyc", vcyc, 7);

    // back-to-back
    start_test();
    drv(1, 32'h03020100, 1, 0);
    repeat (4) drv(1, 32'h07060504, 1, 0);
    idle(6);
    chk_log("b2b", '{9'h000, 9'h001, 9'h002, 9'h103,
                     9'h004, 9'h005, 9'h006, 9'h107});
    chk("b2b_vcyc", vcyc, 8);
    chk("b2b_rpulse", rpulse, 2);
    chk("b2b_lcnt", lcnt, 2);

    // clear during beat 0x01
    start_test();
    drv(1, 32'h03020100, 1, 0);
    drv(0, 32'h0, 1, 0);
    drv(0, 32'h0, 1, 1);
    chk("clr_valid", {31'b0, sval_a}, 0);
    chk("clr_busy", {31'b0, busy_a}, 0);
    chk("clr_ser", {24'b0, ser_a}, 0);
    drv(1, 32'h0A0B0C0D, 1, 0);
    idle(6);
    chk_log("clr", '{9'h000, 9'h001, 9'h00D, 9'h00C, 9'h00B, 9'h10A});
    chk("clr_lcnt", lcnt, 1);

    // asynchronous reset during beat 2
    drv(1, 32'h55667788, 1, 0);
    drv(0, 32'h0, 1, 0);
    drv(0, 32'h0, 1, 0);
    chk("ar_pre", {24'b0, ser_a}, 32'h66);
    #2 rst_n = 0;
    #1;
    chk("ar_valid", {31'b0, sval_a}, 0);
    chk("ar_ser", {24'b0, ser_a}, 0);
    chk("ar_busy", {31'b0, busy_a}, 0);
    chk("ar_ready", {31'b0, ready_a}, 1);
    @(posedge clk);
    #1 rst_n = 1;
    start_test();
    drv(1, 32'h11223344, 1, 0);
    idle(6);
    chk_log("ar", '{9'h044, 9'h033, 9'h022, 9'h111});

    // random traffic on the 32/8 instance
    for (int i = 0; i < 2000; i++)
      drv(($urandom_range(1) == 1), $urandom(),
          ($urandom_range(9) < 7), ($urandom_range(19) == 0));
    idle(6);

    for (int i = 0; i < 5000 && !b_done; i++) @(posedge clk);
    if (!b_done) begin
      nerr++;
      $display("FAIL b_timeout: got 0 expected 1");
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  // random traffic on the degenerate 8/8 instance
  initial begin
    #30;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk);
      #1;
      valid_b  = ($urandom_range(1) == 1);
      data_b   = 8'($urandom());
      sready_b = ($urandom_range(3) != 0);
      clear_b  = ($urandom_range(31) == 0);
    end
    @(posedge clk);
    #1;
    valid_b = 0;
    clear_b = 0;
    b_done  = 1;
  end

endmodule
